// File: rtl/floppy_pkg.sv
// Shared definitions for the floppy sector packer: channel FSM state encoding,
// status byte bit positions and the holding-register beat type.
package floppy_pkg;

    // Per-channel framer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STAT = 2'd2;

    // Bit positions inside the trailing status byte
    localparam int STAT_OVF      = 7;
    localparam int STAT_HDR_ERR  = 6;
    localparam int STAT_DATA_ERR = 5;

    // Kind of byte sitting in a holding register / output register
    typedef enum logic [1:0] {
        BEAT_DATA = 2'b00,
        BEAT_SOF  = 2'b01,
        BEAT_EOF  = 2'b10
    } beat_t;

    // Assemble the status byte {ovf, hdr_err, data_err, 5'b0}
    function automatic logic [7:0] status_byte(input logic ovf,
                                               input logic hdr_err,
                                               input logic data_err);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_OVF]      = ovf;
        s[STAT_HDR_ERR]  = hdr_err;
        s[STAT_DATA_ERR] = data_err;
        return s;
    endfunction

endpackage

// File: rtl/floppy_chan_framer.sv
// One channel of the sector packer: frames a decoder's header/data pulses into
// header, data and status beats held in a single-entry holding register that
// the parent arbiter drains.
module floppy_chan_framer
    import floppy_pkg::*;
#(
    parameter int SECTOR_BYTES = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hdr_dv,
    input  logic [7:0] sector,
    input  logic       hdr_crc_error,
    input  logic       data_dv,
    input  logic [7:0] data,
    input  logic       data_crc_error,
    input  logic       drain,
    output logic       full,
    output logic [7:0] beat_data,
    output beat_t      beat_type,
    output logic       overflow
);

    localparam int CNT_W = $clog2(SECTOR_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SECTOR_BYTES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic             hdr_err;
    logic             data_err;
    logic             ovf;

    logic             load;
    logic [7:0]       load_data;
    beat_t            load_type;
    logic             collide;

    // Decide what (if anything) enters the holding register this cycle;
    // a header always wins over a simultaneous data byte
    always_comb begin
        load      = 1'b0;
        load_data = 8'h00;
        load_type = BEAT_DATA;
        if (hdr_dv) begin
            load      = 1'b1;
            load_data = sector;
            load_type = BEAT_SOF;
        end else if (state == ST_DATA && data_dv) begin
            load      = 1'b1;
            load_data = data;
        end else if (state == ST_STAT && (!full || drain)) begin
            load      = 1'b1;
            load_data = status_byte(ovf, hdr_err, data_err);
            load_type = BEAT_EOF;
        end
    end

    // Overwriting an entry that is not leaving this cycle loses a byte
    assign collide = load && full && !drain;

    // Packet FSM, byte counter and per-packet error/overflow bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            count    <= '0;
            hdr_err  <= 1'b0;
            data_err <= 1'b0;
            ovf      <= 1'b0;
        end else if (hdr_dv) begin
            state    <= ST_DATA;
            count    <= '0;
            hdr_err  <= hdr_crc_error;
            data_err <= 1'b0;
            ovf      <= collide;
        end else if (state == ST_DATA && data_dv) begin
            count <= count + 1'b1;
            if (collide) begin
                ovf <= 1'b1;
            end
            if (count == LAST_CNT) begin
                data_err <= data_crc_error;
                state    <= ST_STAT;
            end
        end else if (state == ST_STAT && load) begin
            state <= ST_IDLE;
            ovf   <= 1'b0;
        end
    end

    // Single-entry holding register; a load in the draining cycle keeps it full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            beat_data <= 8'h00;
            beat_type <= BEAT_DATA;
        end else if (load) begin
            full      <= 1'b1;
            beat_data <= load_data;
            beat_type <= load_type;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    // Sticky overflow: lost bytes or an aborted packet; cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (collide || (hdr_dv && state != ST_IDLE)) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/floppy_sector_packer.sv
// Merges CHANNELS floppy decoder streams into one tagged, framed byte stream.
// Each channel frames its sectors in a floppy_chan_framer; a round-robin
// arbiter moves holding-register entries into a registered output beat.
// Optional build macro FLOPPY_PACKER_STATS_EN adds per-channel saturating
// sector and CRC-error counters.
module floppy_sector_packer
    import floppy_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int SECTOR_BYTES = 512,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [CHANNELS-1:0]   i_Hdr_DV,
    input  logic [8*CHANNELS-1:0] i_Sector,
    input  logic [CHANNELS-1:0]   i_HdrCRCError,
    input  logic [CHANNELS-1:0]   i_Data_DV,
    input  logic [8*CHANNELS-1:0] i_Data,
    input  logic [CHANNELS-1:0]   i_DataCRCError,
    input  logic                  i_Ready,
    output logic                  o_Valid,
    output logic [7:0]            o_Data,
    output logic [CH_W-1:0]       o_Chan,
    output logic                  o_Sof,
    output logic                  o_Eof,
    output logic [CHANNELS-1:0]   o_Overflow
`ifdef FLOPPY_PACKER_STATS_EN
    ,
    output logic [16*CHANNELS-1:0] o_SectorCount,
    output logic [16*CHANNELS-1:0] o_CrcErrCount
`endif
);

    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] drain;
    logic [7:0]          hold_data [CHANNELS];
    beat_t               hold_type [CHANNELS];

    logic [CH_W-1:0]     ptr;
    logic [CH_W-1:0]     sel;
    logic                sel_valid;
    logic                load_out;
    int                  scan_idx;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        floppy_chan_framer #(
            .SECTOR_BYTES(SECTOR_BYTES)
        ) u_framer (
            .clk           (i_Clk),
            .rst_n         (i_Rst_L),
            .hdr_dv        (i_Hdr_DV[gi]),
            .sector        (i_Sector[8*gi +: 8]),
            .hdr_crc_error (i_HdrCRCError[gi]),
            .data_dv       (i_Data_DV[gi]),
            .data          (i_Data[8*gi +: 8]),
            .data_crc_error(i_DataCRCError[gi]),
            .drain         (drain[gi]),
            .full          (full[gi]),
            .beat_data     (hold_data[gi]),
            .beat_type     (hold_type[gi]),
            .overflow      (o_Overflow[gi])
        );
    end

    // Pick the first full channel at or after the pointer; scanning offsets
    // from the far end down lets the nearest one overwrite the choice last
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        scan_idx  = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= CHANNELS) begin
                scan_idx = scan_idx - CHANNELS;
            end
            if (full[CH_W'(scan_idx)]) begin
                sel       = CH_W'(scan_idx);
                sel_valid = 1'b1;
            end
        end
    end

    // The output register takes a new beat when empty or when its beat leaves
    assign load_out = sel_valid && (!o_Valid || i_Ready);

    // Tell the granted channel its holding entry has been taken
    always_comb begin
        drain = '0;
        if (load_out) begin
            drain[sel] = 1'b1;
        end
    end

    // Registered output beat; held stable while stalled. The pointer moves
    // just past the channel that was granted so every channel gets its turn
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Valid <= 1'b0;
            o_Data  <= 8'h00;
            o_Chan  <= '0;
            o_Sof   <= 1'b0;
            o_Eof   <= 1'b0;
            ptr     <= '0;
        end else if (!o_Valid || i_Ready) begin
            o_Valid <= sel_valid;
            if (sel_valid) begin
                o_Data <= hold_data[sel];
                o_Chan <= sel;
                o_Sof  <= (hold_type[sel] == BEAT_SOF);
                o_Eof  <= (hold_type[sel] == BEAT_EOF);
                ptr    <= (int'(sel) == CHANNELS - 1) ? '0 : sel + 1'b1;
            end
        end
    end

`ifdef FLOPPY_PACKER_STATS_EN
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stats
        logic [15:0] sector_cnt;
        logic [15:0] crc_cnt;
        logic        stat_xfer;

        assign stat_xfer = o_Valid && i_Ready && o_Eof && (o_Chan == CH_W'(gi));

        // Count delivered sectors and those carrying a CRC error, saturating
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                sector_cnt <= 16'h0000;
                crc_cnt    <= 16'h0000;
            end else if (stat_xfer) begin
                if (sector_cnt != 16'hFFFF) begin
                    sector_cnt <= sector_cnt + 16'h0001;
                end
                if ((o_Data[STAT_HDR_ERR] || o_Data[STAT_DATA_ERR]) && crc_cnt != 16'hFFFF) begin
                    crc_cnt <= crc_cnt + 16'h0001;
                end
            end
        end

        assign o_SectorCount[16*gi +: 16] = sector_cnt;
        assign o_CrcErrCount[16*gi +: 16] = crc_cnt;
    end
`endif

endmodule
